dmem_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer in front of the 1 KiB byte-addressed data memory.

---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin sequencer for the 1 KiB big-endian doubleword data memory
module dmem_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemoryRead,
    output logic              MemoryWrite,
    input  logic [DATA_W-1:0] MemReadData
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

    logic [1:0]        state;
    logic              last_grant;
    logic              gnt;
    logic              wr;
    logic              pick;
    logic              sel_we;
    logic              legal;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Choose the requester: on contention the port that did not win last time, else whoever asks
    always_comb begin
        pick      = (req0 && req1) ? ~last_grant : req1;
        sel_we    = pick ? we1 : we0;
        sel_addr  = pick ? addr1 : addr0;
        sel_wdata = pick ? wdata1 : wdata0;
        legal     = (sel_addr[2:0] == 3'b000) && (sel_addr <= MAX_ADDR);
    end

    assign busy = state != IDLE;

    // Sequence one access: register the request, strobe for one cycle, capture read data, ack
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            gnt          <= 1'b0;
            wr           <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err          <= 1'b0;
            rsp_rdata    <= '0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            MemoryRead   <= 1'b0;
            MemoryWrite  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    gnt        <= pick;
                    last_grant <= pick;
                    wr         <= sel_we;
                    if (legal) begin
                        MemAddress   <= sel_addr;
                        MemWriteData <= sel_wdata;
                        MemoryRead   <= ~sel_we;
                        MemoryWrite  <= sel_we;
                        state        <= ISSUE;
                    end else begin
                        err       <= 1'b1;
                        rsp_rdata <= '0;
                        ack0      <= ~pick;
                        ack1      <= pick;
                        state     <= RESP;
                    end
                end
                ISSUE: begin
                    MemoryRead  <= 1'b0;
                    MemoryWrite <= 1'b0;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_rdata <= wr ? '0 : MemReadData;
                    ack0      <= ~gnt;
                    ack1      <= gnt;
                    state     <= RESP;
                end
                default: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table, directed and random checks of dmem_arbiter against a doubleword memory model
module tb_dmem_arbiter;
    logic        Clk, Reset_n;
    logic        req0, req1, we0, we1;
    logic [63:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err, busy, MemoryRead, MemoryWrite;
    logic [63:0] rsp_rdata, MemAddress, MemWriteData, MemReadData;

    dmem_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err(err), .rsp_rdata(rsp_rdata), .busy(busy),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .MemReadData(MemReadData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n = 0;
    int fails = 0;
    logic [63:0] pre_val = 64'h0ffbea7deadbeeff;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-addressed memory with registered big-endian doubleword read port
    logic [7:0] mem [0:1023];
    logic       ld;

    function automatic logic [63:0] rd64(input logic [9:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[63-8*i -: 8] = mem[a + 10'(i)];
        return v;
    endfunction

    always @(posedge Clk) begin
        if (ld) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            for (int i = 0; i < 8; i++) mem[24 + i] <= pre_val[63-8*i -: 8];
        end
        if (MemoryWrite)
            for (int i = 0; i < 8; i++) mem[MemAddress[9:0] + 10'(i)] <= MemWriteData[63-8*i -: 8];
        if (MemoryRead) MemReadData <= rd64(MemAddress[9:0]);
    end

    // Protocol monitor: strobes exclusive and single-cycle, acks exclusive
    int   rd_cnt = 0, wr_cnt = 0, ack_cnt = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    always @(negedge Clk) begin
        chk("strobe_overlap", 64'(MemoryRead & MemoryWrite), 64'd0);
        chk("read_strobe_width", 64'(prev_rd & MemoryRead), 64'd0);
        chk("write_strobe_width", 64'(prev_wr & MemoryWrite), 64'd0);
        chk("ack_overlap", 64'(ack0 & ack1), 64'd0);
        rd_cnt  += int'(MemoryRead);
        wr_cnt  += int'(MemoryWrite);
        ack_cnt += int'(ack0) + int'(ack1);
        prev_rd  = MemoryRead;
        prev_wr  = MemoryWrite;
    end

    // Reference model: doubleword contents and round-robin history
    logic [63:0] ref_mem [0:127];
    bit          model_last;

    function automatic bit legal(input logic [63:0] a);
        return a[2:0] == 3'd0 && a <= 64'd1016;
    endfunction

    task automatic expect_of(input bit w, input logic [63:0] a, output bit e_err, output logic [63:0] e_rd);
        e_err = !legal(a);
        e_rd  = (legal(a) && !w) ? ref_mem[a[9:3]] : 64'd0;
    endtask

    task automatic model_done(input bit p, input bit w, input logic [63:0] a, input logic [63:0] d);
        model_last = p;
        if (legal(a) && w) ref_mem[a[9:3]] = d;
    endtask

    task automatic drive(input bit p, input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
        if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic wait_ack(input bit p, output int k);
        k = 0;
        do begin
            @(posedge Clk); #1;
            k++;
        end while (!(p ? ack1 : ack0) && k < 20);
        chk("ack_arrived", 64'(p ? ack1 : ack0), 64'd1);
    endtask

    task automatic check_resp(input bit p, input int k, input int k_exp, input bit e_err, input logic [63:0] e_rd);
        chk(p ? "latency1" : "latency0", 64'(k), 64'(k_exp));
        chk("err", 64'(err), 64'(e_err));
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("other_ack", 64'(p ? ack0 : ack1), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, {62'd0, ack0, ack1}, 64'd0);
        chk({tag, "_err_busy"}, {62'd0, err, busy}, 64'd0);
        chk({tag, "_strobes"}, {62'd0, MemoryRead, MemoryWrite}, 64'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
        chk({tag, "_MemAddress"}, MemAddress, 64'd0);
        chk({tag, "_MemWriteData"}, MemWriteData, 64'd0);
    endtask

    task automatic apply_reset(input bit load);
        Reset_n = 1'b0;
        ld = load;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) @(posedge Clk);
        #1;
        chk_zero("reset");
        ld = 1'b0;
        Reset_n = 1'b1;
        model_last = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic txn(input bit p, input bit w, input logic [63:0] a, input logic [63:0] d,
                       input bit e_err, input logic [63:0] e_rd);
        int k, r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        drive(p, 1, w, a, d);
        wait_ack(p, k);
        check_resp(p, k, e_err ? 1 : 3, e_err, e_rd);
        chk("read_strobes", 64'(rd_cnt - r0), 64'(!e_err && !w));
        chk("write_strobes", 64'(wr_cnt - w0), 64'(!e_err && w));
        @(posedge Clk); #1;
        drive(p, 0, w, a, d);
        model_done(p, w, a, d);
    endtask

    task automatic rtxn(input bit p, input bit w, input logic [63:0] a, input logic [63:0] d);
        bit e_err;
        logic [63:0] e_rd;
        expect_of(w, a, e_err, e_rd);
        txn(p, w, a, d, e_err, e_rd);
    endtask

    task automatic pair(input bit w0, input logic [63:0] a0, input logic [63:0] d0,
                        input bit w1, input logic [63:0] a1, input logic [63:0] d1);
        bit ww [2];
        logic [63:0] aa [2], dd [2];
        bit win, e_err;
        logic [63:0] e_rd;
        int k;
        ww[0] = w0; aa[0] = a0; dd[0] = d0;
        ww[1] = w1; aa[1] = a1; dd[1] = d1;
        win = !model_last;
        drive(0, 1, w0, a0, d0);
        drive(1, 1, w1, a1, d1);
        expect_of(ww[win], aa[win], e_err, e_rd);
        wait_ack(win, k);
        check_resp(win, k, e_err ? 1 : 3, e_err, e_rd);
        model_done(win, ww[win], aa[win], dd[win]);
        @(posedge Clk); #1;
        drive(win, 0, ww[win], aa[win], dd[win]);
        expect_of(ww[!win], aa[!win], e_err, e_rd);
        wait_ack(!win, k);
        check_resp(!win, k, e_err ? 1 : 3, e_err, e_rd);
        model_done(!win, ww[!win], aa[!win], dd[!win]);
        @(posedge Clk); #1;
        drive(!win, 0, ww[!win], aa[!win], dd[!win]);
    endtask

    function automatic logic [63:0] gen_addr();
        int r;
        r = $urandom_range(0, 9);
        return r < 7  ? 64'($urandom_range(0, 127)) << 3 :
               r == 7 ? (64'($urandom_range(0, 127)) << 3) + 64'($urandom_range(1, 7)) :
               r == 8 ? 64'd1024 + (64'($urandom_range(0, 500)) << 3) : 64'd1016;
    endfunction

    typedef struct {
        bit          p;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          e_err;
        logic [63:0] e_rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int k, acks;
        bit e_err, p;
        logic [63:0] e_rd;
        for (int i = 0; i < 128; i++) ref_mem[i] = 64'd0;
        ref_mem[3] = pre_val;
        apply_reset(1);
        tbl[0]  = '{0, 0, 64'h018, 64'h0, 0, pre_val};
        tbl[1]  = '{1, 1, 64'h020, 64'h1122334455667788, 0, 64'h0};
        tbl[2]  = '{1, 0, 64'h020, 64'h0, 0, 64'h1122334455667788};
        tbl[3]  = '{0, 0, 64'h00C, 64'h0, 1, 64'h0};
        tbl[4]  = '{0, 0, 64'h400, 64'h0, 1, 64'h0};
        tbl[5]  = '{0, 0, 64'h3F8, 64'h0, 0, 64'h0};
        tbl[6]  = '{1, 1, 64'h3F8, 64'hA5A5A5A55A5A5A5A, 0, 64'h0};
        tbl[7]  = '{0, 0, 64'h3F8, 64'h0, 0, 64'hA5A5A5A55A5A5A5A};
        tbl[8]  = '{1, 1, 64'h3FC, 64'hFFFFFFFFFFFFFFFF, 1, 64'h0};
        tbl[9]  = '{1, 0, 64'h3F8, 64'h0, 0, 64'hA5A5A5A55A5A5A5A};
        tbl[10] = '{0, 1, 64'h400, 64'hDEAD, 1, 64'h0};
        tbl[11] = '{0, 0, 64'h000, 64'h0, 0, 64'h0};
        for (int i = 0; i < 12; i++)
            txn(tbl[i].p, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].e_err, tbl[i].e_rd);

        // Continuous contention: port 0 first after reset, then strict alternation every 4 cycles
        apply_reset(0);
        drive(0, 1, 0, 64'h18, 0);
        drive(1, 1, 0, 64'h20, 0);
        for (int i = 0; i < 6; i++) begin
            p = bit'(i % 2);
            expect_of(0, p ? 64'h20 : 64'h18, e_err, e_rd);
            wait_ack(p, k);
            check_resp(p, k, i == 0 ? 3 : 4, e_err, e_rd);
            model_last = p;
        end
        @(posedge Clk); #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(posedge Clk); #1;

        // Write then read of the same doubleword from the two ports in contention
        apply_reset(0);
        pair(1, 64'h08, 64'hCAFEF00D12345678, 0, 64'h08, 64'h0);

        // Reset while a read is being issued: outputs clear at once and no ack follows
        drive(0, 1, 0, 64'h18, 0);
        @(posedge Clk); #1;
        chk("issue_strobe", 64'(MemoryRead), 64'd1);
        chk("issue_busy", 64'(busy), 64'd1);
        acks = ack_cnt;
        Reset_n = 1'b0;
        #1;
        chk_zero("midop");
        drive(0, 0, 0, 0, 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        model_last = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        chk("no_ack_after_reset", 64'(ack_cnt - acks), 64'd0);
        rtxn(0, 0, 64'h18, 64'h0);

        for (int i = 0; i < 30; i++)
            rtxn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gen_addr(), {$urandom, $urandom});
        for (int i = 0; i < 10; i++)
            pair(1'($urandom_range(0, 1)), gen_addr(), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), gen_addr(), {$urandom, $urandom});

        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
